// File: rtl/cam_capture_px_pkg.sv
// Shared definitions for the OV7670 capture path: input format codes,
// FSM encoding and RGB332 field layout.
package cam_capture_pkg;
  localparam logic [1:0] MODE_RGB565 = 2'd0;
  localparam logic [1:0] MODE_RGB444 = 2'd1;
  localparam logic [1:0] MODE_YUV_Y  = 2'd2;

  localparam int RGB332_R_W = 3;
  localparam int RGB332_G_W = 3;
  localparam int RGB332_B_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_BYTE1,
    S_BYTE2,
    S_EOF
  } cap_state_t;
endpackage

// File: rtl/cam_capture_px_convert.sv
// Combinational byte-pair to RGB332 converter; also intended for the
// test-pattern source, so it carries no state.
module px_convert
  import cam_capture_pkg::*;
(
  input  logic [1:0] i_mode,
  input  logic [7:0] i_b1,
  input  logic [7:0] i_b2,
  output logic [RGB332_R_W+RGB332_G_W+RGB332_B_W-1:0] o_px
);

  always_comb begin
    o_px = {i_b1[7:5], i_b1[2:0], i_b2[4:3]};
    case (i_mode)
      MODE_RGB444: o_px = {i_b1[3:1], i_b2[7:5], i_b2[3:2]};
      // Luma replicated across all three channels gives a grey ramp.
      MODE_YUV_Y:  o_px = {i_b1[7:5], i_b1[7:5], i_b1[7:6]};
      default:     o_px = {i_b1[7:5], i_b1[2:0], i_b2[4:3]};
    endcase
  end

endmodule

// File: rtl/cam_capture_px.sv
// OV7670 pixel capture: frames the camera byte stream, decimates, converts
// to RGB332 and writes linear addresses into the frame buffer.
module cam_capture_px
  import cam_capture_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int DECIM = 4,
  parameter int AW    = 15,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  input  logic [1:0]    mode,
  input  logic          continuous,
  input  logic          arm,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          busy,
  output logic          ovf
);

  // Counters carry headroom past H_RES/V_RES so overruns stay detectable.
  localparam int XW = $clog2(H_RES + 1) + 1;
  localparam int YW = $clog2(V_RES + 1) + 1;
  localparam logic [XW-1:0] X_LIM  = XW'(H_RES);
  localparam logic [YW-1:0] Y_LIM  = YW'(V_RES);
  localparam logic [XW-1:0] X_MASK = XW'(DECIM - 1);
  localparam logic [YW-1:0] Y_MASK = YW'(DECIM - 1);
  localparam logic [AW-1:0] A_MAX  = AW'((H_RES / DECIM) * (V_RES / DECIM) - 1);

  cap_state_t    r_state, w_next;
  logic          r_vsync, r_href;
  logic          r_cont;
  logic [1:0]    r_mode;
  logic [7:0]    r_b1;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_wr, r_fd, r_busy, r_ovf;

  logic          w_sof, w_pix, w_lend, w_keep, w_out;
  logic [7:0]    w_px;

  px_convert u_conv (
    .i_mode (r_mode),
    .i_b1   (r_b1),
    .i_b2   (px_data),
    .o_px   (w_px)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (arm) w_next = S_WAIT_SOF;
      S_WAIT_SOF: if (r_vsync && !vsync) w_next = S_BYTE1;
      S_BYTE1: begin
        if (vsync)     w_next = S_EOF;
        else if (href) w_next = S_BYTE2;
      end
      // Either a full pixel or an odd trailing byte: both return to BYTE1.
      S_BYTE2:    w_next = vsync ? S_EOF : S_BYTE1;
      S_EOF:      w_next = r_cont ? S_WAIT_SOF : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  assign w_sof  = (r_state == S_WAIT_SOF) && r_vsync && !vsync;
  assign w_pix  = (r_state == S_BYTE2) && !vsync && href;
  assign w_lend = ((r_state == S_BYTE1) || (r_state == S_BYTE2)) && r_href && !href;
  assign w_out  = (r_x >= X_LIM) || (r_y >= Y_LIM);
  assign w_keep = !w_out && ((r_x & X_MASK) == '0) && ((r_y & Y_MASK) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_cont  <= 1'b0;
      r_mode  <= MODE_RGB565;
      r_b1    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_fd    <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vsync <= vsync;
      r_href  <= href;
      r_wr    <= 1'b0;
      r_fd    <= (w_next == S_EOF);

      if ((r_state == S_IDLE) && arm) begin
        r_cont <= continuous;
        r_ovf  <= 1'b0;
        r_busy <= 1'b1;
      end

      if ((r_state == S_EOF) && !r_cont)
        r_busy <= 1'b0;

      // Address advances the cycle after the write it belonged to.
      if (w_sof) begin
        r_mode <= mode;
        r_cont <= continuous;
        r_addr <= '0;
      end else if (r_wr && (r_addr != A_MAX)) begin
        r_addr <= r_addr + AW'(1);
      end

      if ((r_state == S_BYTE1) && !vsync && href)
        r_b1 <= px_data;

      if (w_pix) begin
        if (w_keep) begin
          r_wr   <= 1'b1;
          r_data <= DW'(w_px);
        end else if (w_out) begin
          r_ovf <= 1'b1;
        end
        if (r_x != '1) r_x <= r_x + XW'(1);
      end

      if (w_sof) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_lend) begin
        r_x <= '0;
        if (r_y != '1) r_y <= r_y + YW'(1);
      end
    end
  end

  assign mem_px_addr = r_addr;
  assign mem_px_data = r_data;
  assign px_wr       = r_wr;
  assign frame_done  = r_fd;
  assign busy        = r_busy;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_cam_capture_px.sv
// Directed bench: two instances (4x2 full-rate and 8x4 decimate-by-2) share
// the camera bus; writes and frame_done pulses are logged per instance.
module tb_cam_capture_px;
  logic       clk, rst, vsync, href, continuous, arm;
  logic [7:0] px_data;
  logic [1:0] mode;

  logic [2:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_wr, a_fd, a_busy, a_ovf;
  logic       b_wr, b_fd, b_busy, b_ovf;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] qa_addr[$], qb_addr[$];
  logic [7:0] qa_data[$], qb_data[$];
  int fda = 0, fdb = 0;

  cam_capture_px #(.H_RES(4), .V_RES(2), .DECIM(1), .AW(3), .DW(8)) u_a (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data),
    .mode(mode), .continuous(continuous), .arm(arm),
    .mem_px_addr(a_addr), .mem_px_data(a_data), .px_wr(a_wr),
    .frame_done(a_fd), .busy(a_busy), .ovf(a_ovf));

  cam_capture_px #(.H_RES(8), .V_RES(4), .DECIM(2), .AW(3), .DW(8)) u_b (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data),
    .mode(mode), .continuous(continuous), .arm(arm),
    .mem_px_addr(b_addr), .mem_px_data(b_data), .px_wr(b_wr),
    .frame_done(b_fd), .busy(b_busy), .ovf(b_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_wr) begin qa_addr.push_back(a_addr); qa_data.push_back(a_data); end
    if (b_wr) begin qb_addr.push_back(b_addr); qb_data.push_back(b_data); end
    if (a_fd) fda++;
    if (b_fd) fdb++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
    fda = 0; fdb = 0;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  // ramp: b1 = {x[2:0],2'b00,y[2:0]}, b2 = 0 so RGB565 output is {x,y,2'b00}
  task automatic send_frame(input int lines, input int pix, input logic [7:0] b1,
                            input logic [7:0] b2, input bit ramp, input bit odd);
    vsync = 1'b1; href = 1'b0; repeat (3) tick();
    vsync = 1'b0; repeat (3) tick();
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < pix; p++) begin
        href = 1'b1;
        px_data = ramp ? {p[2:0], 2'b00, l[2:0]} : b1; tick();
        px_data = ramp ? 8'h00 : b2; tick();
      end
      if (odd) begin px_data = 8'h55; tick(); end
      href = 1'b0; repeat (3) tick();
    end
    vsync = 1'b1; repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; vsync = 1'b1; href = 1'b0; px_data = '0; mode = '0;
    continuous = 1'b0; arm = 1'b0;
    repeat (2) tick();
    n_vec++; if (a_addr !== 3'd0) begin n_err++; $display("FAIL reset_addr got %h want 0", a_addr); end
    n_vec++; if (a_data !== 8'd0) begin n_err++; $display("FAIL reset_data got %h want 0", a_data); end
    n_vec++; if (a_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr got %b want 0", a_wr); end
    n_vec++; if (a_fd !== 1'b0) begin n_err++; $display("FAIL reset_fd got %b want 0", a_fd); end
    n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", a_busy); end
    n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", a_ovf); end
    rst = 1'b1; repeat (2) tick();
  endtask

  task automatic test_rgb565();
    clr(); mode = 2'd0; continuous = 1'b0;
    do_arm();
    n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL arm_busy got %b want 1", a_busy); end
    send_frame(2, 4, 8'hF8, 8'h00, 1'b0, 1'b0);
    n_vec++; if (qa_addr.size() != 8) begin n_err++; $display("FAIL rgb565_count got %0d want 8", qa_addr.size()); end
    for (int k = 0; k < qa_addr.size(); k++) begin
      n_vec++;
      if (qa_addr[k] !== 3'(k) || qa_data[k] !== 8'hE0) begin
        n_err++; $display("FAIL rgb565_px%0d got %h/%h want %h/e0", k, qa_addr[k], qa_data[k], 3'(k));
      end
    end
    n_vec++; if (fda != 1) begin n_err++; $display("FAIL rgb565_fd got %0d want 1", fda); end
    n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rgb565_busy got %b want 0", a_busy); end
    n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL rgb565_ovf got %b want 0", a_ovf); end
  endtask

  task automatic test_formats();
    clr(); mode = 2'd1; do_arm();
    send_frame(1, 1, 8'h0F, 8'hF0, 1'b0, 1'b0);
    n_vec++; if (qa_data.size() != 1 || qa_data[0] !== 8'hFC) begin
      n_err++; $display("FAIL rgb444 got %0d writes first %h want 1 x fc", qa_data.size(), qa_data[0]);
    end
    clr(); mode = 2'd2; do_arm();
    send_frame(1, 1, 8'h80, 8'h33, 1'b0, 1'b0);
    n_vec++; if (qa_data.size() != 1 || qa_data[0] !== 8'h92) begin
      n_err++; $display("FAIL yuv_luma got %0d writes first %h want 1 x 92", qa_data.size(), qa_data[0]);
    end
    clr(); mode = 2'd3; do_arm();
    send_frame(1, 1, 8'hF8, 8'h18, 1'b0, 1'b0);
    n_vec++; if (qa_data.size() != 1 || qa_data[0] !== 8'hE3) begin
      n_err++; $display("FAIL mode3 got %0d writes first %h want 1 x e3", qa_data.size(), qa_data[0]);
    end
  endtask

  task automatic test_decim();
    logic [7:0] exp;
    clr(); mode = 2'd0; do_arm();
    send_frame(4, 8, 8'h00, 8'h00, 1'b1, 1'b0);
    n_vec++; if (qb_addr.size() != 8) begin n_err++; $display("FAIL decim_count got %0d want 8", qb_addr.size()); end
    for (int k = 0; k < qb_addr.size(); k++) begin
      exp = {3'(2 * (k % 4)), 3'(2 * (k / 4)), 2'b00};
      n_vec++;
      if (qb_addr[k] !== 3'(k) || qb_data[k] !== exp) begin
        n_err++; $display("FAIL decim_px%0d got %h/%h want %h/%h", k, qb_addr[k], qb_data[k], 3'(k), exp);
      end
    end
    n_vec++; if (b_ovf !== 1'b0) begin n_err++; $display("FAIL decim_ovf got %b want 0", b_ovf); end
    clr(); do_arm();
    send_frame(6, 8, 8'h00, 8'h00, 1'b1, 1'b0);
    n_vec++; if (qb_addr.size() != 8) begin n_err++; $display("FAIL decim_extra_count got %0d want 8", qb_addr.size()); end
    n_vec++; if (b_addr !== 3'd7) begin n_err++; $display("FAIL decim_sat_addr got %0d want 7", b_addr); end
    n_vec++; if (b_ovf !== 1'b1) begin n_err++; $display("FAIL decim_extra_ovf got %b want 1", b_ovf); end
  endtask

  task automatic test_ovf_line();
    clr(); mode = 2'd0; do_arm();
    send_frame(2, 7, 8'hF8, 8'h00, 1'b0, 1'b0);
    n_vec++; if (qa_addr.size() != 8) begin n_err++; $display("FAIL ovf_count got %0d want 8", qa_addr.size()); end
    n_vec++; if (a_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", a_ovf); end
    repeat (5) tick();
    n_vec++; if (a_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", a_ovf); end
    do_arm();
    n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", a_ovf); end
    send_frame(2, 4, 8'hF8, 8'h00, 1'b0, 1'b0);
    n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clean got %b want 0", a_ovf); end
  endtask

  task automatic test_continuous();
    clr(); mode = 2'd0; continuous = 1'b0; do_arm();
    send_frame(2, 4, 8'hF8, 8'h00, 1'b0, 1'b0);
    send_frame(2, 4, 8'hF8, 8'h00, 1'b0, 1'b0);
    n_vec++; if (qa_addr.size() != 8 || fda != 1) begin
      n_err++; $display("FAIL single_shot got %0d writes %0d done want 8/1", qa_addr.size(), fda);
    end
    n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL single_busy got %b want 0", a_busy); end
    clr(); continuous = 1'b1; do_arm();
    send_frame(2, 4, 8'hF8, 8'h00, 1'b0, 1'b0);
    send_frame(2, 4, 8'hF8, 8'h00, 1'b0, 1'b0);
    n_vec++; if (qa_addr.size() != 16 || fda != 2) begin
      n_err++; $display("FAIL cont_count got %0d writes %0d done want 16/2", qa_addr.size(), fda);
    end
    n_vec++; if (qa_addr.size() == 16 && (qa_addr[8] !== 3'd0 || qa_addr[15] !== 3'd7)) begin
      n_err++; $display("FAIL cont_restart got %0d..%0d want 0..7", qa_addr[8], qa_addr[15]);
    end
    n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL cont_busy got %b want 1", a_busy); end
    continuous = 1'b0;
    send_frame(2, 4, 8'hF8, 8'h00, 1'b0, 1'b0);
    n_vec++; if (fda != 3 || a_busy !== 1'b0) begin
      n_err++; $display("FAIL cont_stop got %0d done busy %b want 3/0", fda, a_busy);
    end
  endtask

  task automatic test_partial();
    clr(); do_arm();
    send_frame(2, 4, 8'hF8, 8'h00, 1'b0, 1'b1);
    n_vec++; if (qa_addr.size() != 8 || fda != 1) begin
      n_err++; $display("FAIL odd_byte got %0d writes %0d done want 8/1", qa_addr.size(), fda);
    end
    clr(); do_arm();
    vsync = 1'b1; href = 1'b0; repeat (3) tick();
    vsync = 1'b0; repeat (3) tick();
    for (int p = 0; p < 4; p++) begin
      href = 1'b1; px_data = 8'hF8; tick(); px_data = 8'h00; tick();
    end
    href = 1'b0; repeat (3) tick();
    for (int p = 0; p < 2; p++) begin
      href = 1'b1; px_data = 8'hF8; tick(); px_data = 8'h00; tick();
    end
    px_data = 8'hF8; tick();
    vsync = 1'b1; px_data = 8'h00; tick();
    href = 1'b0; repeat (4) tick();
    n_vec++; if (qa_addr.size() != 6 || fda != 1) begin
      n_err++; $display("FAIL vsync_abort got %0d writes %0d done want 6/1", qa_addr.size(), fda);
    end
    n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL vsync_abort_busy got %b want 0", a_busy); end
  endtask

  task automatic test_reset_mid();
    clr(); do_arm();
    vsync = 1'b1; href = 1'b0; repeat (3) tick();
    vsync = 1'b0; repeat (3) tick();
    href = 1'b1; px_data = 8'hF8; tick(); px_data = 8'h00; tick();
    px_data = 8'hF8; tick();
    px_data = 8'h00; #2 rst = 1'b0; #1;
    n_vec++; if (a_wr !== 1'b0 || a_addr !== 3'd0 || a_data !== 8'd0 || a_busy !== 1'b0 || a_fd !== 1'b0) begin
      n_err++; $display("FAIL rst_mid got wr%b addr%0d data%h busy%b fd%b want all 0", a_wr, a_addr, a_data, a_busy, a_fd);
    end
    tick();
    n_vec++; if (a_wr !== 1'b0) begin n_err++; $display("FAIL rst_mid_wr got %b want 0", a_wr); end
    href = 1'b0; rst = 1'b1; repeat (2) tick();
    n_vec++; if (qa_addr.size() != 1) begin n_err++; $display("FAIL rst_mid_count got %0d want 1", qa_addr.size()); end
    clr();
    send_frame(2, 4, 8'hF8, 8'h00, 1'b0, 1'b0);
    n_vec++; if (qa_addr.size() != 0 || fda != 0) begin
      n_err++; $display("FAIL rst_idle got %0d writes %0d done want 0/0", qa_addr.size(), fda);
    end
  endtask

  initial begin
    test_reset();
    test_rgb565();
    test_formats();
    test_decim();
    test_ovf_line();
    test_continuous();
    test_partial();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
